// File: rtl/user2bft_packetizer.sv
// Leaf transmit packetizer: round-robin over user output streams, per-port credit
// flow control, a held output slot under tree back-pressure, and single-packet resend.
module user2bft_packetizer #(
   parameter int PACKET_BITS           = 49,
   parameter int PAYLOAD_BITS          = 32,
   parameter int NUM_LEAF_BITS         = 5,
   parameter int NUM_PORT_BITS         = 4,
   parameter int NUM_ADDR_BITS         = 7,
   parameter int NUM_OUT_PORTS         = 2,
   parameter int NUM_BRAM_ADDR_BITS    = 7,
   parameter int FREESPACE_UPDATE_SIZE = 64,
   parameter int SEL_BITS              = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1
) (
   input  logic                                   clk_bft,
   input  logic                                   reset,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2interface,
   input  logic [NUM_OUT_PORTS-1:0]               vld_user2interface,
   output logic [NUM_OUT_PORTS-1:0]               ack_interface2user,
   input  logic [NUM_OUT_PORTS*NUM_LEAF_BITS-1:0] dest_leaf,
   input  logic [NUM_OUT_PORTS*NUM_PORT_BITS-1:0] dest_port,
   input  logic                                   credit_vld,
   input  logic [SEL_BITS-1:0]                    credit_sel,
   input  logic                                   bft_ready,
   input  logic                                   resend,
   output logic [PACKET_BITS-1:0]                 dout_leaf_interface2bft
);
   localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
   localparam logic [CREDIT_BITS:0] CREDIT_MAX = (CREDIT_BITS+1)'(1 << NUM_BRAM_ADDR_BITS);
   localparam logic [CREDIT_BITS:0] CREDIT_INC = (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE);
   localparam logic [CREDIT_BITS:0] CREDIT_ONE = (CREDIT_BITS+1)'(1);
   localparam logic [NUM_ADDR_BITS-1:0] SEQ_ONE = NUM_ADDR_BITS'(1);

   logic [NUM_OUT_PORTS-1:0]   cand;
   logic [PACKET_BITS-1:0]     pkt [NUM_OUT_PORTS];
   logic [SEL_BITS-1:0]        rr_ptr_q, rr_ptr_d, win_idx;
   logic                       win_found, slot_free, xfer, serve_resend;
   logic [PACKET_BITS-1:0]     win_pkt, dout_q, dout_d, last_pkt_q, last_pkt_d;
   logic                       resend_pend_q, resend_pend_d, have_last_q, have_last_d;
   logic [CREDIT_BITS-1:0]     credit_q [NUM_OUT_PORTS];
   logic [CREDIT_BITS-1:0]     credit_d [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0]   seq_q [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0]   seq_d [NUM_OUT_PORTS];

   for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_port
      assign cand[gi] = vld_user2interface[gi] && (credit_q[gi] != '0);
      assign pkt[gi]  = {1'b1,
                         dest_leaf[gi*NUM_LEAF_BITS +: NUM_LEAF_BITS],
                         dest_port[gi*NUM_PORT_BITS +: NUM_PORT_BITS],
                         seq_q[gi],
                         din_leaf_user2interface[gi*PAYLOAD_BITS +: PAYLOAD_BITS]};
   end

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_OUT_PORTS;
         if (!win_found && cand[idx]) begin
            win_found = 1'b1;
            win_idx   = SEL_BITS'(idx);
         end
      end
   end

   always_comb begin
      slot_free          = !dout_q[PACKET_BITS-1] || bft_ready;
      xfer               = win_found && slot_free && !resend_pend_q;
      serve_resend       = resend_pend_q && slot_free;
      win_pkt            = pkt[win_idx];
      ack_interface2user = '0;
      if (xfer) ack_interface2user[win_idx] = 1'b1;

      rr_ptr_d    = xfer ? win_idx : rr_ptr_q;
      last_pkt_d  = xfer ? win_pkt : last_pkt_q;
      have_last_d = have_last_q || xfer;
      // Pulses arriving while a resend is already pending collapse into it.
      if (serve_resend) resend_pend_d = 1'b0;
      else              resend_pend_d = resend_pend_q || (resend && have_last_q);

      if (xfer)              dout_d = win_pkt;
      else if (serve_resend) dout_d = last_pkt_q;
      else if (bft_ready)    dout_d = '0;
      else                   dout_d = dout_q;
   end

   always_comb begin
      logic [CREDIT_BITS:0] sum;
      sum = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         sum = {1'b0, credit_q[i]};
         if (credit_vld && int'(credit_sel) == i) sum = sum + CREDIT_INC;
         if (xfer && int'(win_idx) == i)          sum = sum - CREDIT_ONE;
         if (sum > CREDIT_MAX) sum = CREDIT_MAX;
         credit_d[i] = sum[CREDIT_BITS-1:0];
         seq_d[i]    = (xfer && int'(win_idx) == i) ? seq_q[i] + SEQ_ONE : seq_q[i];
      end
   end

   always_ff @(posedge clk_bft) begin
      if (reset) begin
         rr_ptr_q      <= SEL_BITS'(NUM_OUT_PORTS - 1);
         dout_q        <= '0;
         last_pkt_q    <= '0;
         resend_pend_q <= 1'b0;
         have_last_q   <= 1'b0;
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_q[i] <= CREDIT_MAX[CREDIT_BITS-1:0];
            seq_q[i]    <= '0;
         end
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         dout_q        <= dout_d;
         last_pkt_q    <= last_pkt_d;
         resend_pend_q <= resend_pend_d;
         have_last_q   <= have_last_d;
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_q[i] <= credit_d[i];
            seq_q[i]    <= seq_d[i];
         end
      end
   end

   assign dout_leaf_interface2bft = dout_q;
endmodule

// File: tb/tb_user2bft_packetizer.sv
// Directed bench for user2bft_packetizer: arbitration, credits, back-pressure,
// resend and mid-stream reset, with hand-computed expected packets.
module tb_user2bft_packetizer;
   logic        clk_bft = 1'b0;
   logic        reset;
   logic [31:0] din0, din1;
   logic [1:0]  vld;
   logic [1:0]  ack;
   logic        credit_vld;
   logic [0:0]  credit_sel;
   logic        bft_ready;
   logic        resend;
   logic [48:0] dout;

   int n_cmp = 0;
   int n_err = 0;
   int n_ack;

   always #5 clk_bft = ~clk_bft;

   user2bft_packetizer dut (
      .clk_bft                 (clk_bft),
      .reset                   (reset),
      .din_leaf_user2interface ({din1, din0}),
      .vld_user2interface      (vld),
      .ack_interface2user      (ack),
      .dest_leaf               ({5'd7, 5'd3}),
      .dest_port               ({4'd5, 4'd2}),
      .credit_vld              (credit_vld),
      .credit_sel              (credit_sel),
      .bft_ready               (bft_ready),
      .resend                  (resend),
      .dout_leaf_interface2bft (dout)
   );

   function automatic logic [48:0] pk(input logic [4:0] l, input logic [3:0] p,
                                      input logic [6:0] s, input logic [31:0] w);
      return {1'b1, l, p, s, w};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
         $display("ok   %-14s observed=%h", tag, obs);
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_bft);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; vld = 2'b00; credit_vld = 1'b0; resend = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; din0 = '0; din1 = '0; vld = '0; credit_vld = 1'b0;
      credit_sel = '0; bft_ready = 1'b1; resend = 1'b0;
      tick(); tick();
      chk("rst_dout", 64'(dout), 64'd0);
      chk("rst_ack", 64'(ack), 64'd0);
      reset = 1'b0;

      // single port, seq increments
      vld = 2'b01; din0 = 32'hDEADBEEF; #1;
      chk("p0_ack", 64'(ack), 64'd1);
      tick();
      chk("p0_pkt0", 64'(dout), 64'(pk(5'd3, 4'd2, 7'd0, 32'hDEADBEEF)));
      din0 = 32'h11111111; #1;
      chk("p0_ack2", 64'(ack), 64'd1);
      tick();
      chk("p0_pkt1", 64'(dout), 64'(pk(5'd3, 4'd2, 7'd1, 32'h11111111)));
      vld = 2'b00;
      tick();
      chk("drain_zero", 64'(dout), 64'd0);

      // round-robin between both ports
      do_reset();
      vld = 2'b11; din0 = 32'hA0000000; din1 = 32'hB0000000; #1;
      chk("rr_ack0", 64'(ack), 64'b01);
      tick();
      chk("rr_pkt0", 64'(dout), 64'(pk(5'd3, 4'd2, 7'd0, 32'hA0000000)));
      din0 = 32'hA0000001; #1;
      chk("rr_ack1", 64'(ack), 64'b10);
      tick();
      chk("rr_pkt1", 64'(dout), 64'(pk(5'd7, 4'd5, 7'd0, 32'hB0000000)));
      din1 = 32'hB0000001; #1;
      chk("rr_ack2", 64'(ack), 64'b01);
      tick();
      chk("rr_pkt2", 64'(dout), 64'(pk(5'd3, 4'd2, 7'd1, 32'hA0000001)));
      #1;
      chk("rr_ack3", 64'(ack), 64'b10);
      tick();
      chk("rr_pkt3", 64'(dout), 64'(pk(5'd7, 4'd5, 7'd1, 32'hB0000001)));
      vld = 2'b00;

      // credit exhaustion, replenish and seq wrap on port 0
      do_reset();
      n_ack = 0;
      vld = 2'b01;
      for (int c = 0; c < 130; c++) begin
         din0 = 32'(n_ack); #1;
         if (ack[0]) n_ack++;
         tick();
         if (c == 127) chk("seq127_pkt", 64'(dout), 64'(pk(5'd3, 4'd2, 7'd127, 32'd127)));
      end
      chk("credit_128", 64'(n_ack), 64'd128);
      chk("no_credit_ack", 64'(ack), 64'd0);
      credit_vld = 1'b1; credit_sel = 1'b0; #1;
      chk("upd_not_yet", 64'(ack), 64'd0);
      tick();
      credit_vld = 1'b0; din0 = 32'd128; #1;
      chk("upd_ack", 64'(ack), 64'd1);
      tick();
      chk("seq_wrap_pkt", 64'(dout), 64'(pk(5'd3, 4'd2, 7'd0, 32'd128)));
      n_ack = 129;
      for (int c = 0; c < 70; c++) begin
         din0 = 32'(n_ack); #1;
         if (ack[0]) n_ack++;
         tick();
      end
      chk("credit_plus64", 64'(n_ack), 64'd192);

      // update on a full port saturates at 128
      vld = 2'b00; credit_vld = 1'b1; credit_sel = 1'b1;
      tick();
      credit_vld = 1'b0; credit_sel = 1'b0;
      n_ack = 0; vld = 2'b10;
      for (int c = 0; c < 140; c++) begin
         din1 = 32'(n_ack); #1;
         if (ack[1]) n_ack++;
         tick();
      end
      chk("credit_sat", 64'(n_ack), 64'd128);
      vld = 2'b00;

      // back-pressure holds the slot
      do_reset();
      vld = 2'b01; din0 = 32'h55; bft_ready = 1'b1;
      tick();
      din0 = 32'h66; bft_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_ack", 64'(ack), 64'd0);
         tick();
         chk("bp_hold", 64'(dout), 64'(pk(5'd3, 4'd2, 7'd0, 32'h55)));
      end
      bft_ready = 1'b1; #1;
      chk("bp_release_ack", 64'(ack), 64'd1);
      tick();
      chk("bp_next_pkt", 64'(dout), 64'(pk(5'd3, 4'd2, 7'd1, 32'h66)));
      vld = 2'b00;

      // resend without history is ignored
      do_reset();
      resend = 1'b1;
      tick();
      resend = 1'b0;
      tick();
      chk("resend_ign", 64'(dout), 64'd0);

      // resend: two pulses, one duplicate
      vld = 2'b01; din0 = 32'h12345678;
      tick();
      chk("rs_orig", 64'(dout), 64'(pk(5'd3, 4'd2, 7'd0, 32'h12345678)));
      vld = 2'b00; bft_ready = 1'b0; resend = 1'b1;
      tick();
      tick();
      resend = 1'b0; vld = 2'b01; din0 = 32'h9ABC; #1;
      chk("rs_hold_ack", 64'(ack), 64'd0);
      bft_ready = 1'b1; #1;
      chk("rs_serve_ack", 64'(ack), 64'd0);
      tick();
      chk("rs_dup", 64'(dout), 64'(pk(5'd3, 4'd2, 7'd0, 32'h12345678)));
      #1;
      chk("rs_after_ack", 64'(ack), 64'd1);
      tick();
      chk("rs_next_seq", 64'(dout), 64'(pk(5'd3, 4'd2, 7'd1, 32'h9ABC)));
      vld = 2'b00;
      tick();
      chk("rs_single", 64'(dout), 64'd0);

      // reset mid-stream with valid output and pending resend
      vld = 2'b01; din0 = 32'h77;
      tick();
      vld = 2'b00; bft_ready = 1'b0; resend = 1'b1;
      tick();
      resend = 1'b0; reset = 1'b1;
      tick();
      chk("mid_rst_dout", 64'(dout), 64'd0);
      chk("mid_rst_ack", 64'(ack), 64'd0);
      reset = 1'b0; bft_ready = 1'b1; vld = 2'b11; din0 = 32'h88; din1 = 32'h99; #1;
      chk("post_rst_ack", 64'(ack), 64'b01);
      tick();
      chk("post_rst_pkt", 64'(dout), 64'(pk(5'd3, 4'd2, 7'd0, 32'h88)));
      vld = 2'b00;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/user2bft_packetizer.md
# user2bft_packetizer

Transmit-side packetizer for a leaf, clocked on `clk_bft`. It accepts 32-bit words from up to NUM_OUT_PORTS user operator output streams over the ap_vld/ap_ack handshake and formats each word into a 49-bit BFT packet. It arbitrates round-robin between ports and enforces per-port credit flow control against the destination buffer. It holds emitted packets under tree back-pressure and can re-emit the last packet on `resend`.

## Interface
- PACKET_BITS, 49, BFT packet width
- PAYLOAD_BITS, 32, user word width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, sequence/address field width
- NUM_OUT_PORTS, 2, user output streams handled
- NUM_BRAM_ADDR_BITS, 7, log2 of destination buffer depth (credit ceiling 2^7 = 128)
- FREESPACE_UPDATE_SIZE, 64, credits restored per freespace update

Ports:
- clk_bft  in  1  sole clock
- reset  in  1  synchronous, active-high
- din_leaf_user2interface  in  NUM_OUT_PORTS*32  user words, port i at [32i+31:32i]
- vld_user2interface  in  NUM_OUT_PORTS  per-port ap_vld
- ack_interface2user  out  NUM_OUT_PORTS  per-port ap_ack
- dest_leaf  in  NUM_OUT_PORTS*5  static destination leaf per port
- dest_port  in  NUM_OUT_PORTS*4  static destination port per port
- credit_vld  in  1  freespace-update pulse
- credit_sel  in  clog2(NUM_OUT_PORTS), min 1  port receiving the update
- bft_ready  in  1  tree accepts dout this cycle
- resend  in  1  request re-emission of last packet
- dout_leaf_interface2bft  out  49  packet: [48] valid, [47:43] leaf, [42:39] port, [38:32] seq, [31:0] payload

## Operation
- Transfer on port i occurs in any cycle with vld[i] && ack[i]. The user holds data/vld until acked.
- ack[i] is combinational: 1 iff i is the round-robin winner, vld[i]=1, credit[i]>0, no resend is being served, and the output slot is free. The slot is free when dout[48]=0 or bft_ready=1.
- At most one ack bit is high per cycle.
- Round-robin: candidates are ports with vld && credit>0. The search starts at rr_ptr+1 mod NUM_OUT_PORTS. rr_ptr updates to the winner only on a transfer. Reset rr_ptr = NUM_OUT_PORTS-1, so port 0 has first priority.
- Packet fields: {1'b1, dest_leaf[i], dest_port[i], seq[i], word}. seq[i] is a 7-bit per-port counter, reset 0, incremented mod 128 per transfer (127 -> 0).
- credit[i] is 8 bits, reset 128. Rules:
  - Each transfer on i decrements credit[i].
  - credit_vld adds 64 to credit[credit_sel], saturating at 128.
  - Decrement and update on the same port in the same cycle: net +63, then saturate.
  - credit_sel >= NUM_OUT_PORTS is ignored.
- Output register: loaded on transfer. Held unchanged while dout[48]=1 && bft_ready=0. Cleared to 0 when bft_ready=1 and nothing new is loaded.
- last_pkt register copies every packet loaded by a transfer. have_last flag: reset 0, set on first transfer.
- resend:
  - A resend pulse sets resend_pend if have_last=1; otherwise the pulse is ignored.
  - When resend_pend=1 and the slot is free, load last_pkt into dout, clear resend_pend, and assert no ack that cycle.
  - Resend does not touch seq, credit or rr_ptr.
  - Multiple pulses while pending collapse into one.
- Reset mid-operation: all state returns to reset values the next edge. Any in-flight packet is dropped.

## Timing
- Reset values: dout_leaf_interface2bft = 0, ack_interface2user = 0, credits 128, seq 0, resend_pend 0, have_last 0.
- Latency: word transferred at edge N appears on dout with valid=1 from N until the edge at which bft_ready=1 is sampled.
- Throughput: 1 packet/cycle with bft_ready held high and credits available. Back-to-back transfers from the same or different ports are allowed.
- credit_vld at edge N is visible to ack from cycle N+1.
- resend sampled at edge N; re-emitted packet is on dout no earlier than N+1.

## Test plan
- Single port 0, dest_leaf=3, dest_port=2, word 0xDEADBEEF, bft_ready=1 -> dout = {1,5'd3,4'd2,7'd0,32'hDEADBEEF} one cycle after ack; next word carries seq 1.
- Both ports vld continuously, bft_ready=1 -> acks alternate 0,1,0,1; port 0 first after reset; seq per port increments independently.
- Port 0 streams 130 words with no credit_vld -> exactly 128 acks, then ack stays 0. A credit_vld with sel=0 allows 64 more. Seq wraps 127 -> 0 at word 128.
- bft_ready=0 for 5 cycles with a packet loaded -> dout stable, ack=0 throughout. On bft_ready=1 the next word loads the same cycle.
- After a packet with payload 0x12345678, pulse resend twice while bft_ready=0 -> exactly one duplicate of that packet follows it, no ack that cycle, credit unchanged.
- Assert reset mid-stream with dout valid and resend pending -> next cycle dout=0, acks 0, credits 128, seq 0. The next transfer uses seq 0 from port 0.
